// File: rtl/mem_bank_hs.sv
// Banked, byte-strobed SRAM with valid/ready requests and a credit-protected, in-order response FIFO.
// Optional power-up zero fill is enabled by defining MEM_BANK_HS_INIT_EN.

// One 8-bit storage lane with a synchronous read port.
// Latency: read data appears the cycle after cs.
// Backpressure: none; every cs is serviced.
module mem_core #(
   parameter int ROW_WIDTH = 7
) (
   input  logic                 clk,
   input  logic                 cs,
   input  logic                 we,
   input  logic [ROW_WIDTH-1:0] addr,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata
);
   logic [7:0] mem [2**ROW_WIDTH];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end
endmodule

// Generic circular FIFO; any DEPTH, pointers wrap at DEPTH-1.
// Latency: pushed entry is visible at the head the following cycle.
// Backpressure: none internally; caller must not push when full or pop when empty.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign empty    = (count == '0);
endmodule

// Word-interleaved bank array behind a request/response handshake.
// Latency: response valid two cycles after accept, one request per cycle sustained.
// Backpressure: req_ready_o drops when FIFO entries plus the in-flight read would fill RSP_DEPTH.
module mem_bank_hs #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_SIZE  = 2,
   parameter int NUM_BANKS  = 2,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_we_i,
   input  logic [ADDR_WIDTH-1:0]         req_addr_i,
   input  logic [8*(2**DATA_SIZE)-1:0]   req_wdata_i,
   input  logic [(2**DATA_SIZE)-1:0]     req_wstrb_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic                          rsp_we_o,
   output logic [8*(2**DATA_SIZE)-1:0]   rsp_rdata_o,
   output logic                          init_done_o
);
   localparam int DATA_BYTES = 2**DATA_SIZE;
   localparam int DATA_WIDTH = 8*DATA_BYTES;
   localparam int BANK_BITS  = $clog2(NUM_BANKS);
   localparam int BW         = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int WORD_WIDTH = ADDR_WIDTH - DATA_SIZE;
   localparam int ROW_WIDTH  = WORD_WIDTH - BANK_BITS;
   localparam int CW         = $clog2(RSP_DEPTH+1);

   logic [WORD_WIDTH-1:0] word;
   logic [BW-1:0]         bank;
   logic [ROW_WIDTH-1:0]  row;
   logic                  addr_unused;
   logic                  accept;
   logic                  init_wr;
   logic [ROW_WIDTH-1:0]  init_row;

   assign word        = req_addr_i[ADDR_WIDTH-1:DATA_SIZE];
   assign row         = word[WORD_WIDTH-1:BANK_BITS];
   assign addr_unused = ^req_addr_i[DATA_SIZE-1:0];

   generate
      if (BANK_BITS == 0) begin : g_one_bank
         assign bank = '0;
      end else begin : g_banks
         assign bank = word[BANK_BITS-1:0];
      end
   endgenerate

`ifdef MEM_BANK_HS_INIT_EN
   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
   state_t state;

   // The IDLE exit cycle already writes row 0, so the fill takes exactly 2**ROW_WIDTH cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         init_row <= '0;
      end else begin
         case (state)
            IDLE: begin
               state    <= INIT;
               init_row <= init_row + 1'b1;
            end
            INIT: begin
               init_row <= init_row + 1'b1;
               if (init_row == '1) state <= RUN;
            end
            default: ;
         endcase
      end
   end

   assign init_wr     = !rst_i && (state != RUN);
   assign init_done_o = !rst_i && (state == RUN);
`else
   assign init_row    = '0;
   assign init_wr     = 1'b0;
   assign init_done_o = !rst_i;
`endif

   logic                  inflight;
   logic                  tag_we;
   logic [BW-1:0]         tag_bank;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic [DATA_WIDTH:0]   head_dat;
   logic [DATA_WIDTH:0]   push_dat;
   logic                  pop;

   // Credit uses registered occupancy only, so ready never depends on this cycle's handshakes.
   assign req_ready_o = init_done_o &&
                        (({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < (CW+1)'(RSP_DEPTH));
   assign accept      = req_valid_i && req_ready_o;

   logic [NUM_BANKS-1:0]                 bank_cs;
   logic [DATA_BYTES-1:0]                lane_we;
   logic [ROW_WIDTH-1:0]                 mem_row;
   logic [DATA_WIDTH-1:0]                mem_wdata;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

   always_comb begin
      bank_cs   = '0;
      lane_we   = '0;
      mem_row   = row;
      mem_wdata = req_wdata_i;
      if (init_wr) begin
         bank_cs   = '1;
         lane_we   = '1;
         mem_row   = init_row;
         mem_wdata = '0;
      end else if (accept) begin
         bank_cs[bank] = 1'b1;
         lane_we       = {DATA_BYTES{req_we_i}} & req_wstrb_i;
      end
   end

   generate
      for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
         for (genvar l = 0; l < DATA_BYTES; l++) begin : g_lane
            mem_core #(.ROW_WIDTH(ROW_WIDTH)) u_core (
               .clk   (clk_i),
               .cs    (bank_cs[b]),
               .we    (lane_we[l]),
               .addr  (mem_row),
               .wdata (mem_wdata[8*l +: 8]),
               .rdata (bank_rdata[b][8*l +: 8])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight <= 1'b0;
         tag_we   <= 1'b0;
         tag_bank <= '0;
      end else begin
         inflight <= accept;
         tag_we   <= req_we_i;
         tag_bank <= bank;
      end
   end

   // Core rdata is stale on writes, so write responses carry zero.
   assign push_dat = {tag_we, tag_we ? {DATA_WIDTH{1'b0}} : bank_rdata[tag_bank]};

   fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (inflight),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (fifo_count),
      .empty    (fifo_empty)
   );

   assign rsp_valid_o = !rst_i && !fifo_empty;
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign rsp_we_o    = rsp_valid_o && head_dat[DATA_WIDTH];
   assign rsp_rdata_o = rsp_valid_o ? head_dat[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_mem_bank_hs.sv
// Directed bench for mem_bank_hs: handshake timing, byte strobes, banking, credit and reset.
module tb_mem_bank_hs;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_we;
   logic [31:0] rsp_rdata;
   logic        init_done;

   int checks   = 0;
   int failures = 0;
   int acc;
   logic [31:0] t5_exp;

   logic [9:0]  ra [4] = '{10'h010, 10'h014, 10'h3FC, 10'h013};
   logic [31:0] rd [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hA0A0A0A0};

   always #5 clk = ~clk;

   mem_bank_hs dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_wstrb_i (req_wstrb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_we_o    (rsp_we),
      .rsp_rdata_o (rsp_rdata),
      .init_done_o (init_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!init_done && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_init_timeout"}, n < 400, 1'b1);
   endtask

   // Waits for a response with rsp_ready low, checks it, then pops it with a one-cycle ready pulse.
   task automatic expect_rsp(input string tag, input logic we, input logic [31:0] data);
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_timeout"}, n < 20, 1'b1);
      chk({tag, "_we"}, rsp_we, we);
      chk({tag, "_dat"}, rsp_rdata, data);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the directed sequence completed");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      rsp_ready = 1'b0;
      drive(1'b1, 1'b1, 10'h010, 32'h55555555, 4'hF);
      repeat (3) tick();
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_we",    rsp_we, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_init_done", init_done, 1'b0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      rst = 1'b0;
      wait_init("boot");
      chk("boot_init_done", init_done, 1'b1);
      chk("boot_req_ready", req_ready, 1'b1);

      // Write then read the same word on consecutive cycles.
      rsp_ready = 1'b1;
      drive(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
      tick();
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      @(negedge clk);
      chk("t1_wr_valid", rsp_valid, 1'b1);
      chk("t1_wr_we",    rsp_we, 1'b1);
      chk("t1_wr_dat",   rsp_rdata, 32'h0);
      tick();
      @(negedge clk);
      chk("t1_rd_valid", rsp_valid, 1'b1);
      chk("t1_rd_we",    rsp_we, 1'b0);
      chk("t1_rd_dat",   rsp_rdata, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("t1_empty", rsp_valid, 1'b0);
      tick();
      rsp_ready = 1'b0;

      // Partial strobe merges lanes 0 and 2.
      drive(1'b1, 1'b1, 10'h014, 32'h11223344, 4'hF);
      tick();
      drive(1'b1, 1'b1, 10'h014, 32'hAABBCCDD, 4'h5);
      tick();
      drive(1'b1, 1'b0, 10'h014, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t2_w0", 1'b1, 32'h0);
      expect_rsp("t2_w1", 1'b1, 32'h0);
      expect_rsp("t2_rd", 1'b0, 32'h11BB33DD);

      // Both banks and the last row, then back-to-back reads on consecutive cycles.
      drive(1'b1, 1'b1, 10'h010, 32'hA0A0A0A0, 4'hF);
      tick();
      drive(1'b1, 1'b1, 10'h014, 32'hB1B1B1B1, 4'hF);
      tick();
      drive(1'b1, 1'b1, 10'h3FC, 32'hC2C2C2C2, 4'hF);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t3_w0", 1'b1, 32'h0);
      expect_rsp("t3_w1", 1'b1, 32'h0);
      expect_rsp("t3_w2", 1'b1, 32'h0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(1'b1, 1'b0, ra[c], 32'h0, 4'h0);
         else       drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
         @(negedge clk);
         if (c >= 2) begin
            chk($sformatf("t3_rd%0d_valid", c-2), rsp_valid, 1'b1);
            chk($sformatf("t3_rd%0d_dat", c-2), rsp_rdata, rd[c-2]);
         end
         tick();
      end
      @(negedge clk);
      chk("t3_empty", rsp_valid, 1'b0);
      tick();
      rsp_ready = 1'b0;

      // Credit exhaustion with responses blocked.
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b1, 1'b0, ra[c % 4], 32'h0, 4'h0);
         @(negedge clk);
         if (req_ready) acc++;
         if (c == 4) chk("t4_ready_after4", req_ready, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      chk("t4_accepted", acc, 4);
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_dat0", rsp_rdata, 32'hA0A0A0A0);
      tick();
      @(negedge clk);
      chk("t4_hold_dat1", rsp_rdata, 32'hA0A0A0A0);
      chk("t4_full_ready", req_ready, 1'b0);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_pop0_dat", rsp_rdata, 32'hA0A0A0A0);
      chk("t4_pop0_ready", req_ready, 1'b0);
      tick();
      @(negedge clk);
      chk("t4_after_pop_ready", req_ready, 1'b1);
      chk("t4_pop1_dat", rsp_rdata, 32'hB1B1B1B1);
      tick();
      @(negedge clk);
      chk("t4_pop2_dat", rsp_rdata, 32'hC2C2C2C2);
      tick();
      @(negedge clk);
      chk("t4_pop3_dat", rsp_rdata, 32'hA0A0A0A0);
      tick();
      @(negedge clk);
      chk("t4_empty", rsp_valid, 1'b0);
      tick();
      rsp_ready = 1'b0;

      // Reset with responses queued and in flight; memory must survive.
      drive(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t5_wr", 1'b1, 32'h0);
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      drive(1'b1, 1'b0, 10'h014, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_valid", rsp_valid, 1'b0);
      chk("t5_rst_dat",   rsp_rdata, 32'h0);
      chk("t5_rst_ready", req_ready, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_post_valid", rsp_valid, 1'b0);
      tick();
      wait_init("t5");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t5_stale%0d", c), rsp_valid, 1'b0);
      end
      tick();
`ifdef MEM_BANK_HS_INIT_EN
      t5_exp = 32'h0;
`else
      t5_exp = 32'hDEADBEEF;
`endif
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t5_retain", 1'b0, t5_exp);

`ifdef MEM_BANK_HS_INIT_EN
      // Zero fill takes 128 cycles, and a reset part-way restarts it.
      drive(1'b1, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t6_wr", 1'b1, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         chk($sformatf("t6_busy%0d", i), {init_done, req_ready}, 2'b00);
      end
      @(negedge clk);
      chk("t6_done", {init_done, req_ready}, 2'b11);
      tick();
      drive(1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
      tick();
      drive(1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
      expect_rsp("t6_zero", 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (50) @(negedge clk);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         chk($sformatf("t6_restart%0d", i), {init_done, req_ready}, 2'b00);
      end
      @(negedge clk);
      chk("t6_restart_done", {init_done, req_ready}, 2'b11);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
